// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word types plus BTB constants so fetch and resolve stages agree.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_2bit;
    localparam int       BTB_ENTRIES    = 4;
    localparam lc3b_2bit BTB_WEAK_TAKEN = 2'b10;
    function automatic int weak_taken(int bits);
        return 1 << (bits - 1);
    endfunction
endpackage

// File: rtl/btb_victim_sel.sv
// btb_victim_sel: picks the allocation victim (lowest invalid entry, else round-robin) and owns rr_ptr.
module btb_victim_sel #(
    parameter int ENTRIES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ENTRIES-1:0] valid_i,
    input  logic               alloc_i,
    output logic [ENTRIES-1:0] victim_o,
    output logic               from_rr_o
);
    localparam int PW = $clog2(ENTRIES);
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    always_comb begin
        victim_o  = ENTRIES'(1) << rr_ptr_q;
        from_rr_o = 1'b1;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                victim_o  = ENTRIES'(1) << i;
                from_rr_o = 1'b0;
            end
        end
    end
    // The pointer only advances when it actually supplied the victim.
    assign rr_ptr_d = (alloc_i && from_rr_o) ? rr_ptr_q + PW'(1) : rr_ptr_q;
    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: fully-associative BTB with combinational lookup, saturating direction counters
// and invalid-first / round-robin allocation on taken update misses.
module btb_assoc
    import lc3b_types::*;
#(
    parameter int ENTRIES  = BTB_ENTRIES,
    parameter int WIDTH    = $bits(lc3b_word),
    parameter int CTR_BITS = $bits(lc3b_2bit)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_check,
    output logic             hit,
    output logic             predicted_taken,
    output logic [WIDTH-1:0] predicted_target,
    input  logic             update,
    input  logic [WIDTH-1:0] update_pc,
    input  logic [WIDTH-1:0] update_target,
    input  logic             update_taken,
    input  logic             flush
);
    localparam logic [CTR_BITS-1:0] WEAK = CTR_BITS'(weak_taken(CTR_BITS));
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [WIDTH-1:0]    tag_q [ENTRIES];
    logic [WIDTH-1:0]    tag_d [ENTRIES];
    logic [WIDTH-1:0]    tgt_q [ENTRIES];
    logic [WIDTH-1:0]    tgt_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];
    logic [ENTRIES-1:0]  upd_vec, upd_oh, victim;
    logic [CTR_BITS-1:0] hit_ctr;
    logic                alloc, from_rr;
    // Descending scan so the lowest matching index wins on a tag collision.
    always_comb begin
        hit              = 1'b0;
        predicted_target = '0;
        hit_ctr          = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == pc_check) begin
                hit              = 1'b1;
                predicted_target = tgt_q[i];
                hit_ctr          = ctr_q[i];
            end
        end
    end
    assign predicted_taken = hit & hit_ctr[CTR_BITS-1];
    always_comb begin
        upd_vec = '0;
        for (int i = 0; i < ENTRIES; i++) upd_vec[i] = valid_q[i] && tag_q[i] == update_pc;
    end
    assign upd_oh = upd_vec & (~upd_vec + ENTRIES'(1));
    assign alloc  = update && !flush && update_taken && upd_vec == '0;
    btb_victim_sel #(.ENTRIES(ENTRIES)) u_victim (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_q),
        .alloc_i   (alloc),
        .victim_o  (victim),
        .from_rr_o (from_rr)
    );
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        for (int i = 0; i < ENTRIES; i++) begin
            if (flush) begin
                valid_d[i] = 1'b0;
            end else if (update && upd_oh[i]) begin
                ctr_d[i] = update_taken ? ((ctr_q[i] == '1) ? ctr_q[i] : ctr_q[i] + CTR_BITS'(1))
                                        : ((ctr_q[i] == '0) ? ctr_q[i] : ctr_q[i] - CTR_BITS'(1));
                tgt_d[i] = update_taken ? update_target : tgt_q[i];
            end else if (alloc && victim[i]) begin
                valid_d[i] = 1'b1;
                tag_d[i]   = update_pc;
                tgt_d[i]   = update_target;
                ctr_d[i]   = WEAK;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            tag_q   <= '{default: '0};
            tgt_q   <= '{default: '0};
            ctr_q   <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
        end
    end
endmodule
